// File: rtl/sum_arb_pkg.sv
// Shared types and defaults for the sum-adder arbiter: FSM state encoding,
// default widths/timeout and an index-width helper.
package sum_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int NW_DEF      = 8;
    localparam int SW_DEF      = 16;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping to index 0.
module rr_priority_picker
    import sum_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            any_req
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scan from the farthest rotated position down so the closest one to ptr wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                grant   = wrap_idx(ptr, k);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sum_adder_arbiter.sv
// Round-robin front end that shares one sum-adder unit among NREQ requesters,
// with a watchdog that aborts a transaction the adder never completes.
module sum_adder_arbiter
    import sum_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int NW      = NW_DEF,
    parameter int SW      = SW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*NW-1:0] n_in,
    output logic [NREQ-1:0]    req_ack,
    output logic [SW-1:0]      result,
    output logic [NREQ-1:0]    result_valid,
    output logic [NREQ-1:0]    err,
    output logic               busy,
    output logic               adder_start,
    output logic [NW-1:0]      adder_n,
    input  logic               adder_done,
    input  logic [SW-1:0]      adder_sum
);

    localparam int IW  = idx_width(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    arb_state_e      state_q;
    logic [IW-1:0]   ptr_q, ptr_d, gnt_q, pick;
    logic            any_req;
    logic [NW-1:0]   operand_q, pick_n;
    logic [SW-1:0]   result_q;
    logic [WDW-1:0]  wdog_q;
    logic [NREQ-1:0] req_ack_q, result_valid_q, err_q;
    logic            adder_start_q;

    rr_priority_picker #(.NREQ(NREQ)) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .grant   (pick),
        .any_req (any_req)
    );

    assign pick_n = n_in[int'(pick)*NW +: NW];
    assign ptr_d  = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            gnt_q          <= '0;
            operand_q      <= '0;
            result_q       <= '0;
            wdog_q         <= '0;
            req_ack_q      <= '0;
            result_valid_q <= '0;
            err_q          <= '0;
            adder_start_q  <= 1'b0;
        end else begin
            req_ack_q      <= '0;
            result_valid_q <= '0;
            err_q          <= '0;
            adder_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q       <= ISSUE;
                        gnt_q         <= pick;
                        operand_q     <= pick_n;
                        req_ack_q     <= ONE_HOT0 << pick;
                        adder_start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    wdog_q  <= '0;
                end
                WAIT: begin
                    if (adder_done) begin
                        state_q        <= RESP;
                        result_q       <= adder_sum;
                        result_valid_q <= ONE_HOT0 << gnt_q;
                    end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        // TIMEOUT full WAIT cycles have elapsed without completion.
                        state_q <= RESP;
                        err_q   <= ONE_HOT0 << gnt_q;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    ptr_q     <= ptr_d;
                    operand_q <= '0;
                    wdog_q    <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack      = req_ack_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);
    assign adder_start  = adder_start_q;
    assign adder_n      = operand_q;

endmodule

// File: tb/tb_sum_adder_arbiter.sv
// Directed-plus-random bench for sum_adder_arbiter with a behavioural adder
// model and a round-robin reference model.
module tb_sum_adder_arbiter;

    localparam int NREQ    = 4;
    localparam int NW      = 8;
    localparam int SW      = 16;
    localparam int TIMEOUT = 1023;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req;
    logic [NREQ*NW-1:0] n_in;
    logic [NREQ-1:0]    req_ack;
    logic [SW-1:0]      result;
    logic [NREQ-1:0]    result_valid;
    logic [NREQ-1:0]    err;
    logic               busy;
    logic               adder_start;
    logic [NW-1:0]      adder_n;
    logic               adder_done;
    logic [SW-1:0]      adder_sum;

    int vectors = 0;
    int miscompares = 0;

    int            ref_ptr = 0;
    logic [SW-1:0] exp_result = '0;

    int            model_lat = 1;
    int            model_cnt = 0;
    logic [NW-1:0] model_n = '0;
    logic          model_done = 1'b0;
    logic [SW-1:0] model_sum = '0;
    logic          spur_done = 1'b0;
    logic [SW-1:0] spur_sum = 16'hbeef;

    assign adder_done = model_done | spur_done;
    assign adder_sum  = spur_done ? spur_sum : model_sum;

    always #5 clk = ~clk;

    sum_adder_arbiter #(.NREQ(NREQ), .NW(NW), .SW(SW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .n_in         (n_in),
        .req_ack      (req_ack),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .busy         (busy),
        .adder_start  (adder_start),
        .adder_n      (adder_n),
        .adder_done   (adder_done),
        .adder_sum    (adder_sum)
    );

    function automatic logic [SW-1:0] tri_sum(input int n);
        return SW'(n * (n + 1) / 2);
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] rv, input int p);
        for (int k = 0; k < NREQ; k++)
            if (rv[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Sum-adder stand-in: returns 1+..+N, model_lat cycles after the start
    // pulse; model_lat = 0 means it never answers.
    initial begin
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!rst_n) begin
                model_cnt = 0;
            end else if (adder_start) begin
                model_cnt = model_lat;
                model_n   = adder_n;
            end else if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    model_sum  = tri_sum(int'(model_n));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=hung required=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", {req_ack, result, result_valid, err, busy, adder_start, adder_n}, 64'd0);
        tick();
        check("rst_hold", {result_valid, err, busy}, 64'd0);
        rst_n      = 1'b1;
        ref_ptr    = 0;
        exp_result = '0;
        $display("reset pulse applied");
    endtask

    task automatic do_txn(input logic [NREQ-1:0] rv, input int lat, input bit noise,
                          input bit spur, input int fixed_n);
        logic [NW-1:0] nv [NREQ];
        int g;
        int k;
        int budget;
        for (int i = 0; i < NREQ; i++) begin
            nv[i] = (fixed_n >= 0) ? NW'(fixed_n) : NW'($urandom);
            n_in[i*NW +: NW] = nv[i];
        end
        g = ref_pick(rv, ref_ptr);
        model_lat = lat;
        if (spur) begin
            req = '0;
            spur_done = 1'b1;
            tick();
            tick();
            check("spur_idle_busy", busy, 64'd0);
            check("spur_idle_valid", result_valid, 64'd0);
        end
        req = rv;
        tick();
        check("issue_ack", req_ack, 64'(1) << g);
        check("issue_start", adder_start, 64'd1);
        check("issue_n", adder_n, nv[g]);
        check("issue_busy", busy, 64'd1);
        k = 0;
        budget = ((lat == 0) ? TIMEOUT : lat) + 10;
        while (result_valid == '0 && err == '0 && k < budget) begin
            if (noise) req = NREQ'($urandom);
            tick();
            k++;
            if (spur) spur_done = 1'b0;
            if (k == 1) begin
                check("wait_start_low", {adder_start, req_ack}, 64'd0);
                check("wait_n_held", adder_n, nv[g]);
            end
        end
        req = rv;
        check("resp_latency", k, (lat == 0) ? TIMEOUT + 1 : lat + 1);
        if (lat == 0) begin
            check("timeout_err", err, 64'(1) << g);
            check("timeout_no_valid", result_valid, 64'd0);
        end else begin
            exp_result = tri_sum(int'(nv[g]));
            check("resp_valid", result_valid, 64'(1) << g);
            check("resp_no_err", err, 64'd0);
        end
        check("resp_result", result, exp_result);
        check("resp_n_held", adder_n, nv[g]);
        ref_ptr = (g + 1) % NREQ;
        tick();
        check("idle_busy", busy, 64'd0);
        check("idle_pulses", {result_valid, err, req_ack, adder_start}, 64'd0);
        check("idle_n_zero", adder_n, 64'd0);
        check("idle_result_hold", result, exp_result);
        $display("txn req=%b grant=%0d lat=%0d n=%0d result=%0h err=%b",
                 rv, g, lat, nv[g], result, (lat == 0));
    endtask

    initial begin
        req  = '0;
        n_in = '0;
        pulse_reset();

        // Single request with the documented 10 -> 55 case, then minimum latency.
        do_txn(4'b0001, 12, 1'b0, 1'b0, 10);
        do_txn(4'b0010, 1, 1'b0, 1'b0, -1);

        // Simultaneous requests from reset: 0 then 2, after which ptr is 3.
        pulse_reset();
        do_txn(4'b0101, 2, 1'b0, 1'b0, -1);
        do_txn(4'b0101, 2, 1'b0, 1'b0, -1);
        do_txn(4'b1111, 1, 1'b0, 1'b0, -1);

        // Fairness with everyone requesting and noise on req while busy.
        for (int t = 0; t < 8; t++)
            do_txn(4'b1111, $urandom_range(1, 6), 1'b1, 1'b0, -1);

        do_txn(4'b0010, 3, 1'b0, 1'b0, 0);
        do_txn(4'b0100, 4, 1'b0, 1'b1, -1);
        do_txn(4'b0010, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 6; t++)
            do_txn(NREQ'($urandom_range(1, 15)), $urandom_range(1, 8), 1'b1, 1'b0, -1);
        req = '0;

        // Abort mid-WAIT while ptr is 1; reset must also bring ptr back to 0.
        do_txn(4'b0001, 1, 1'b0, 1'b0, -1);
        req = 4'b0100;
        model_lat = 0;
        tick();
        check("abort_issue_ack", req_ack, 64'b0100);
        req = '0;
        repeat (5) tick();
        check("abort_wait_busy", busy, 64'd1);
        pulse_reset();
        tick();
        check("post_reset_idle", {busy, result_valid, err}, 64'd0);
        do_txn(4'b1001, 2, 1'b0, 1'b0, -1);
        do_txn(4'b1000, 2, 1'b0, 1'b0, -1);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
